sram_256x4: RTL and testbench

SRAM_256X4 -- requirements
Module: sram_256x4

---
 rtl/sram_256x4_if.sv | 43 ++++
 rtl/sram_256x4.sv | 136 +++++++++++++
 tb/tb_sram_256x4.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/sram_256x4_if.sv
// Upstream-to-SRAM bus for the 256x4 test memory.
// The shared 4-bit data bus is resolved here: upstream and the SRAM each
// present a value plus an enable, and the bus wire carries whichever side
// is driving, or high-Z when neither is.
interface sram_256x4_if;
  logic [7:0] address;
  logic       cs;
  logic       we;
  logic       oe;

  // Upstream drive of the shared bus (write data)
  logic [3:0] wr_data;
  logic       wr_en;

  // SRAM drive of the shared bus (read data)
  logic [3:0] rd_data;
  logic       rd_en;

  // Resolved shared data bus
  wire  [3:0] data;

  // Status from the SRAM
  logic [1:0] mode;
  logic [8:0] wr_count;
  logic [8:0] rd_count;
  logic       uninit_rd;
  logic       err_conflict;

  // The SRAM only enables its driver while we=0 and upstream only while
  // we=1, so the two enables never overlap in legal use; the read side
  // wins if they ever do.
  assign data = rd_en ? rd_data : (wr_en ? wr_data : 4'bzzzz);

  modport master (
    output address, cs, we, oe, wr_data, wr_en,
    input  data, rd_en, mode, wr_count, rd_count, uninit_rd, err_conflict
  );

  modport slave (
    input  address, cs, we, oe, data,
    output rd_data, rd_en, mode, wr_count, rd_count, uninit_rd, err_conflict
  );
endinterface

// File: rtl/sram_256x4.sv
// 256 x 4-bit synchronous SRAM with a per-word valid bit, one-cycle read
// latency onto a shared tri-state bus, saturating access counters, an
// uninitialised-read pulse, a sticky cs/we/oe conflict flag and a phase FSM
// reporting the access type seen at each edge.
module sram_256x4 (
  input  logic           clk,
  input  logic           reset,
  sram_256x4_if.slave    bus
);

  typedef enum logic [1:0] {
    MODE_IDLE     = 2'b00,
    MODE_WRITE    = 2'b01,
    MODE_READ     = 2'b10,
    MODE_CONFLICT = 2'b11
  } mode_t;

  localparam logic [8:0] CNT_MAX = 9'h1FF;

  // Storage: word contents are never reset, only the valid bits are
  logic [3:0]   r_mem [0:255];
  logic [255:0] r_valid;

  // Read pipeline and status registers
  logic [3:0] r_rd_q;
  logic       r_drv_q;
  logic       r_uninit_rd;
  logic       r_err_conflict;
  logic [8:0] r_wr_count;
  logic [8:0] r_rd_count;
  mode_t      r_mode;

  // Access decode
  logic       w_wr_acc;
  logic       w_rd_acc;
  logic       w_conflict;
  logic       w_addr_valid;
  logic [3:0] w_mem_word;
  logic       w_bus_drive;

  // Write wins over read when both we and oe are high, so a read is only
  // accepted with we low.
  assign w_wr_acc     = bus.cs & bus.we;
  assign w_rd_acc     = bus.cs & ~bus.we & bus.oe;
  assign w_conflict   = bus.cs & bus.we & bus.oe;
  assign w_addr_valid = r_valid[bus.address];
  assign w_mem_word   = r_mem[bus.address];

  // Store the bus value into the addressed word on an accepted write
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[bus.address] <= bus.data;
    end
  end

  // Mark a word as written; reset forgets every previous write
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= '0;
    end else if (w_wr_acc) begin
      r_valid[bus.address] <= 1'b1;
    end
  end

  // Capture read data one cycle ahead of the bus, returning zero for words
  // never written; the driver flag drops at any edge without a read
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_q      <= 4'b0000;
      r_drv_q     <= 1'b0;
      r_uninit_rd <= 1'b0;
    end else if (w_rd_acc) begin
      r_rd_q      <= w_addr_valid ? w_mem_word : 4'b0000;
      r_drv_q     <= 1'b1;
      r_uninit_rd <= ~w_addr_valid;
    end else begin
      r_drv_q     <= 1'b0;
      r_uninit_rd <= 1'b0;
    end
  end

  // Count accepted writes, holding at the top value instead of wrapping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_count <= 9'd0;
    end else if (w_wr_acc && (r_wr_count != CNT_MAX)) begin
      r_wr_count <= r_wr_count + 9'd1;
    end
  end

  // Count accepted reads, holding at the top value instead of wrapping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_count <= 9'd0;
    end else if (w_rd_acc && (r_rd_count != CNT_MAX)) begin
      r_rd_count <= r_rd_count + 9'd1;
    end
  end

  // Latch any edge where cs, we and oe were high together until reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err_conflict <= 1'b0;
    end else if (w_conflict) begin
      r_err_conflict <= 1'b1;
    end
  end

  // Phase FSM: the state reflects the control combination sampled this edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mode <= MODE_IDLE;
    end else begin
      case ({bus.cs, bus.we, bus.oe})
        3'b111:  r_mode <= MODE_CONFLICT;
        3'b110:  r_mode <= MODE_WRITE;
        3'b101:  r_mode <= MODE_READ;
        default: r_mode <= MODE_IDLE;
      endcase
    end
  end

  // The bus driver is gated combinationally by the live controls so that
  // dropping cs/oe, raising we, or asserting reset releases the bus at once
  // rather than at the next edge.
  assign w_bus_drive = r_drv_q & bus.cs & bus.oe & ~bus.we;

  assign bus.rd_data      = r_rd_q;
  assign bus.rd_en        = w_bus_drive;
  assign bus.mode         = r_mode;
  assign bus.wr_count     = r_wr_count;
  assign bus.rd_count     = r_rd_count;
  assign bus.uninit_rd    = r_uninit_rd;
  assign bus.err_conflict = r_err_conflict;

endmodule

// File: tb/tb_sram_256x4.sv
// Self-checking bench for sram_256x4: directed scenarios plus a random
// phase, all compared against an array-based behavioural model.
module tb_sram_256x4;

  logic clk;
  logic reset;

  sram_256x4_if bus ();

  sram_256x4 dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  logic [3:0] m_mem [256];
  bit         m_valid [256];
  int         m_wr;
  int         m_rd;
  bit         m_uninit;
  bit         m_err;
  bit         m_drv;
  logic [3:0] m_rdq;
  logic [1:0] m_mode;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 256; i++) m_valid[i] = 1'b0;
    m_wr = 0; m_rd = 0; m_uninit = 0; m_err = 0; m_drv = 0;
    m_rdq = 4'b0000; m_mode = 2'b00;
  endtask

  // Compare every DUT output against the model for the inputs currently held
  task automatic check_all(input string tag);
    bit exp_drive;
    exp_drive = m_drv && bus.cs && bus.oe && !bus.we;
    check({tag, ".mode"},   16'(bus.mode),         16'(m_mode));
    check({tag, ".wrcnt"},  16'(bus.wr_count),     16'(m_wr));
    check({tag, ".rdcnt"},  16'(bus.rd_count),     16'(m_rd));
    check({tag, ".uninit"}, 16'(bus.uninit_rd),    16'(m_uninit));
    check({tag, ".err"},    16'(bus.err_conflict), 16'(m_err));
    check({tag, ".drive"},  16'(bus.rd_en),        16'(exp_drive));
    if (exp_drive) check({tag, ".data"}, 16'(bus.data), 16'(m_rdq));
  endtask

  // One clocked access: drive controls, take the edge, advance the model, check
  task automatic cycle(input logic c, input logic w, input logic o,
                       input logic [7:0] a, input logic [3:0] d, input string tag);
    bus.cs = c; bus.we = w; bus.oe = o; bus.address = a;
    bus.wr_data = d; bus.wr_en = w;
    @(posedge clk);
    #1;
    if (c && w) begin
      m_mem[a] = d;
      m_valid[a] = 1'b1;
      if (m_wr < 511) m_wr++;
      m_drv = 0; m_uninit = 0;
      if (o) begin m_err = 1; m_mode = 2'b11; end
      else m_mode = 2'b01;
    end else if (c && o) begin
      m_rdq = m_valid[a] ? m_mem[a] : 4'b0000;
      m_uninit = !m_valid[a];
      m_drv = 1;
      if (m_rd < 511) m_rd++;
      m_mode = 2'b10;
    end else begin
      m_drv = 0; m_uninit = 0; m_mode = 2'b00;
    end
    check_all(tag);
  endtask

  initial begin
    bus.cs = 0; bus.we = 0; bus.oe = 0; bus.address = 8'd0;
    bus.wr_data = 4'd0; bus.wr_en = 0;
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    check("reset.wrcnt0", 16'(bus.wr_count), 16'd0);
    @(negedge clk);
    reset = 1'b0;

    // 34 writes of 1010, bus never driven by the SRAM
    for (int i = 0; i < 34; i++) cycle(1, 1, 0, 8'(i), 4'b1010, "wr34");
    check("wr34.count", 16'(bus.wr_count), 16'd34);
    check("wr34.mode",  16'(bus.mode),     16'd1);

    // Read them back
    for (int i = 0; i < 34; i++) begin
      cycle(1, 0, 1, 8'(i), 4'b0000, "rd34");
      check("rd34.value", 16'(bus.data), 16'b1010);
    end
    check("rd34.count", 16'(bus.rd_count), 16'd34);

    // Never-written address gives zero and a single-cycle uninit pulse
    cycle(1, 0, 1, 8'hC8, 4'b0000, "uninit");
    check("uninit.data",  16'(bus.data),      16'd0);
    check("uninit.pulse", 16'(bus.uninit_rd), 16'd1);
    cycle(0, 0, 0, 8'hC8, 4'b0000, "uninit_end");
    check("uninit.clear", 16'(bus.uninit_rd), 16'd0);

    // Conflict: write still happens, flag sticks
    cycle(1, 1, 1, 8'd5, 4'b0110, "conflict");
    check("conflict.mode", 16'(bus.mode), 16'd3);
    check("conflict.err",  16'(bus.err_conflict), 16'd1);
    cycle(0, 1, 1, 8'd5, 4'b0000, "conflict_idle");
    check("conflict.sticky", 16'(bus.err_conflict), 16'd1);
    cycle(1, 0, 1, 8'd5, 4'b0000, "conflict_rd");
    check("conflict.rdval", 16'(bus.data), 16'b0110);

    // Random traffic over a narrow address window to mix hits and misses
    for (int i = 0; i < 300; i++) begin
      logic [7:0] ra;
      ra = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(30, 45));
      cycle(($urandom_range(0, 7) != 0), 1'($urandom), 1'($urandom), ra,
            4'($urandom), "rand");
    end

    // Reset in the middle of a driven read releases the bus immediately
    cycle(1, 0, 1, 8'd3, 4'b0000, "pre_reset_rd");
    check("pre_reset.drive", 16'(bus.rd_en), 16'd1);
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    check("midreset.drive", 16'(bus.rd_en),    16'd0);
    check("midreset.wrcnt", 16'(bus.wr_count), 16'd0);
    check("midreset.rdcnt", 16'(bus.rd_count), 16'd0);
    check("midreset.err",   16'(bus.err_conflict), 16'd0);
    check("midreset.mode",  16'(bus.mode),     16'd0);
    @(negedge clk);
    reset = 1'b0;
    cycle(1, 0, 1, 8'd0, 4'b0000, "post_reset_rd");
    check("post_reset.data",   16'(bus.data),      16'd0);
    check("post_reset.uninit", 16'(bus.uninit_rd), 16'd1);

    // 600 writes saturate the write counter
    for (int i = 0; i < 600; i++) cycle(1, 1, 0, 8'(i), 4'(i), "wr600");
    check("wr600.sat", 16'(bus.wr_count), 16'd511);

    // Dropping oe while the read data is on the bus releases it in-cycle
    cycle(1, 0, 1, 8'd7, 4'b0000, "oe_drop_rd");
    check("oe_drop.before", 16'(bus.rd_en), 16'd1);
    #2;
    bus.oe = 1'b0;
    #1;
    check("oe_drop.after", 16'(bus.rd_en), 16'd0);
    cycle(0, 0, 0, 8'd0, 4'b0000, "final_idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
